// File: rtl/usrt_pkg.sv
// Shared USRT definitions: frame state encoding, parity modes, parity helper.
package usrt_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } usrt_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Turns the XOR reduction of the data bits into the parity bit sent on the line.
  function automatic logic par_bit(input logic xor_red, input int mode);
    return (mode == PAR_ODD) ? ~xor_red : xor_red;
  endfunction

endpackage

// File: rtl/usrt_tx_txdatreg.sv
// Transmit holding register: one-entry buffer between the bus and the shifter.
module txdatreg
  import usrt_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              i_Pclk,
  input  logic              i_Reset,
  input  logic              i_Push,
  input  logic [DATA_W-1:0] i_Data,
  input  logic              i_Xfer,
  input  logic              i_ClrOvf,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_Full,
  output logic              o_Ovf
);

  logic [DATA_W-1:0] r_Data;
  logic              r_Full;
  logic              r_Ovf;

  // Store a pushed byte when there is room, or when the current one leaves this same cycle.
  always_ff @(posedge i_Pclk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_Data <= '0;
      r_Full <= 1'b0;
    end else if (i_Push && (!r_Full || i_Xfer)) begin
      r_Data <= i_Data;
      r_Full <= 1'b1;
    end else if (i_Xfer) begin
      r_Full <= 1'b0;
    end
  end

  // Sticky overflow on a dropped push; a new drop beats a simultaneous clear.
  always_ff @(posedge i_Pclk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_Ovf <= 1'b0;
    end else if (i_Push && r_Full && !i_Xfer) begin
      r_Ovf <= 1'b1;
    end else if (i_ClrOvf) begin
      r_Ovf <= 1'b0;
    end
  end

  assign o_Data = r_Data;
  assign o_Full = r_Full;
  assign o_Ovf  = r_Ovf;

endmodule

// File: rtl/usrt_tx.sv
// USRT transmitter: holding register feeding a frame serialiser paced by i_BitEn.
module usrt_tx
  import usrt_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              i_Pclk,
  input  logic              i_Reset,
  input  logic              i_BitEn,
  input  logic              i_Push,
  input  logic [DATA_W-1:0] i_Data,
  input  logic              i_ClrOvf,
  output logic              o_Tx,
  output logic              o_Full,
  output logic              o_Busy,
  output logic              o_Empty,
  output logic              o_Ovf
);

  localparam int CNT_W = 4;

  usrt_state_e       r_State;
  logic [DATA_W-1:0] r_Shift;
  logic [CNT_W-1:0]  r_BitCnt;
  logic [1:0]        r_StopCnt;
  logic              r_Par;
  logic              r_Tx;

  logic [DATA_W-1:0] w_HoldData;
  logic              w_HoldFull;
  logic              w_HoldOvf;
  logic              w_LastStop;
  logic              w_Xfer;

  // A frame may start from IDLE or on the final stop-bit boundary (back-to-back frames).
  assign w_LastStop = (r_StopCnt == 2'(STOP_BITS));
  assign w_Xfer     = i_BitEn && w_HoldFull &&
                      ((r_State == IDLE) || ((r_State == STOP) && w_LastStop));

  txdatreg #(
    .DATA_W (DATA_W)
  ) u_txdatreg (
    .i_Pclk   (i_Pclk),
    .i_Reset  (i_Reset),
    .i_Push   (i_Push),
    .i_Data   (i_Data),
    .i_Xfer   (w_Xfer),
    .i_ClrOvf (i_ClrOvf),
    .o_Data   (w_HoldData),
    .o_Full   (w_HoldFull),
    .o_Ovf    (w_HoldOvf)
  );

  // Frame FSM with registered line output; all progress is gated by the bit strobe.
  always_ff @(posedge i_Pclk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_State   <= IDLE;
      r_Tx      <= 1'b1;
      r_Shift   <= '0;
      r_BitCnt  <= '0;
      r_StopCnt <= '0;
      r_Par     <= 1'b0;
    end else if (w_Xfer) begin
      r_Shift <= w_HoldData;
      r_Par   <= par_bit(^w_HoldData, PARITY);
      r_Tx    <= 1'b0;
      r_State <= START;
    end else if (i_BitEn) begin
      case (r_State)
        IDLE: begin
          r_Tx <= 1'b1;
        end
        START: begin
          r_Tx     <= r_Shift[0];
          r_Shift  <= r_Shift >> 1;
          r_BitCnt <= CNT_W'(1);
          r_State  <= DATA;
        end
        DATA: begin
          if (r_BitCnt == CNT_W'(DATA_W)) begin
            if (PARITY != PAR_NONE) begin
              r_Tx    <= r_Par;
              r_State <= usrt_pkg::PARITY;
            end else begin
              r_Tx      <= 1'b1;
              r_StopCnt <= 2'd1;
              r_State   <= STOP;
            end
          end else begin
            r_Tx     <= r_Shift[0];
            r_Shift  <= r_Shift >> 1;
            r_BitCnt <= r_BitCnt + CNT_W'(1);
          end
        end
        usrt_pkg::PARITY: begin
          r_Tx      <= 1'b1;
          r_StopCnt <= 2'd1;
          r_State   <= STOP;
        end
        STOP: begin
          if (w_LastStop) begin
            r_Tx    <= 1'b1;
            r_State <= IDLE;
          end else begin
            r_StopCnt <= r_StopCnt + 2'd1;
          end
        end
        default: begin
          r_Tx    <= 1'b1;
          r_State <= IDLE;
        end
      endcase
    end
  end

  assign o_Tx    = r_Tx;
  assign o_Full  = w_HoldFull;
  assign o_Busy  = (r_State != IDLE);
  assign o_Empty = !w_HoldFull && (r_State == IDLE);
  assign o_Ovf   = w_HoldOvf;

endmodule

// File: tb/tb_usrt_tx.sv
// Scoreboard bench for usrt_tx: four parameterisations driven by shared stimulus.
module tb_usrt_tx;

  localparam int ND = 4;
  localparam int DW [ND] = '{8, 8, 8, 5};
  localparam int PR [ND] = '{0, 1, 2, 0};
  localparam int SB [ND] = '{1, 2, 1, 2};

  logic       clk;
  logic       i_Reset;
  logic       i_BitEn;
  logic       i_Push;
  logic [7:0] i_Data;
  logic       i_ClrOvf;

  logic w_tx [ND];
  logic w_full [ND];
  logic w_busy [ND];
  logic w_empty [ND];
  logic w_ovf [ND];

  int checks = 0;
  int errors = 0;
  int div = 0;

  // Reference model state, per DUT
  logic [8:0] exp_q [ND][$];
  logic [8:0] cur [ND];
  bit         in_frame [ND];
  int         pos [ND];
  int         idle_cnt [ND];
  int         gap_last [ND];
  bit         ovf_exp [ND];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    usrt_tx #(
      .DATA_W    (DW[g]),
      .PARITY    (PR[g]),
      .STOP_BITS (SB[g])
    ) u_dut (
      .i_Pclk   (clk),
      .i_Reset  (i_Reset),
      .i_BitEn  (i_BitEn),
      .i_Push   (i_Push),
      .i_Data   (i_Data[DW[g]-1:0]),
      .i_ClrOvf (i_ClrOvf),
      .o_Tx     (w_tx[g]),
      .o_Full   (w_full[g]),
      .o_Busy   (w_busy[g]),
      .o_Empty  (w_empty[g]),
      .o_Ovf    (w_ovf[g])
    );
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask

  function automatic int flen(input int d);
    return 1 + DW[d] + ((PR[d] != 0) ? 1 : 0) + SB[d];
  endfunction

  function automatic logic [8:0] dmask(input int d, input logic [7:0] v);
    return 9'(v) & 9'((1 << DW[d]) - 1);
  endfunction

  // Line level expected at bit position p of a frame carrying data v.
  function automatic logic exp_bit(input int d, input logic [8:0] v, input int p);
    if (p == 0) return 1'b0;
    if (p <= DW[d]) return v[p-1];
    if (PR[d] != 0 && p == DW[d] + 1) return ($countones(v) % 2 == 1) ^ (PR[d] == 2);
    return 1'b1;
  endfunction

  // Monitors: follow the line at each bit boundary and compare against popped frames.
  for (genvar g = 0; g < ND; g++) begin : g_mon
    always begin
      @(posedge clk);
      if (i_BitEn && i_Reset) begin
        #1;
        if (in_frame[g]) begin
          pos[g]++;
          if (pos[g] < flen(g)) chk("frame_bit", g, 32'(w_tx[g]), 32'(exp_bit(g, cur[g], pos[g])));
          else in_frame[g] = 1'b0;
        end
        if (!in_frame[g]) begin
          if (exp_q[g].size() == 0) begin
            chk("idle_line", g, 32'(w_tx[g]), 32'd1);
            idle_cnt[g]++;
          end else if (w_tx[g] == 1'b0) begin
            cur[g]      = exp_q[g].pop_front();
            in_frame[g] = 1'b1;
            pos[g]      = 0;
            gap_last[g] = idle_cnt[g];
            idle_cnt[g] = 0;
          end else begin
            idle_cnt[g]++;
          end
        end
      end
    end
  end

  // One clock of stimulus: check flags, update model, drive inputs, advance to next negedge.
  task automatic step(input logic p, input logic [7:0] dat, input logic clr);
    bit be;
    bit xfer_now;
    bit rej;
    for (int d = 0; d < ND; d++) begin
      chk("full", d, 32'(w_full[d]), 32'(exp_q[d].size() != 0));
      chk("busy", d, 32'(w_busy[d]), 32'(in_frame[d]));
      chk("empty", d, 32'(w_empty[d]), 32'(exp_q[d].size() == 0 && !in_frame[d]));
      chk("ovf", d, 32'(w_ovf[d]), 32'(ovf_exp[d]));
    end
    be  = (div == 3);
    div = (div + 1) % 4;
    for (int d = 0; d < ND; d++) begin
      xfer_now = be && exp_q[d].size() != 0 && (!in_frame[d] || pos[d] == flen(d) - 1);
      rej = 1'b0;
      if (p) begin
        if (exp_q[d].size() == 0 || xfer_now) exp_q[d].push_back(dmask(d, dat));
        else rej = 1'b1;
      end
      if (rej) ovf_exp[d] = 1'b1;
      else if (clr) ovf_exp[d] = 1'b0;
    end
    i_BitEn  = be;
    i_Push   = p;
    i_Data   = dat;
    i_ClrOvf = clr;
    @(negedge clk);
  endtask

  function automatic bit all_started();
    for (int d = 0; d < ND; d++)
      if (!in_frame[d] || exp_q[d].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit all_done();
    for (int d = 0; d < ND; d++)
      if (in_frame[d] || exp_q[d].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_started();
    int n = 0;
    while (!all_started() && n < 400) begin step(1'b0, 8'h00, 1'b0); n++; end
    for (int d = 0; d < ND; d++) chk("start_seen", d, 32'(exp_q[d].size()), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (!all_done() && n < 600) begin step(1'b0, 8'h00, 1'b0); n++; end
    step(1'b0, 8'h00, 1'b0);
    for (int d = 0; d < ND; d++) begin
      chk("drain_queue", d, 32'(exp_q[d].size()), 32'd0);
      chk("drain_empty", d, 32'(w_empty[d]), 32'd1);
    end
  endtask

  initial begin
    i_Reset = 1'b0; i_BitEn = 1'b0; i_Push = 1'b0; i_Data = 8'h00; i_ClrOvf = 1'b0;
    for (int d = 0; d < ND; d++) begin
      in_frame[d] = 1'b0; pos[d] = 0; idle_cnt[d] = 0; gap_last[d] = 0; ovf_exp[d] = 1'b0; cur[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk("rst_tx", d, 32'(w_tx[d]), 32'd1);
      chk("rst_full", d, 32'(w_full[d]), 32'd0);
      chk("rst_busy", d, 32'(w_busy[d]), 32'd0);
      chk("rst_empty", d, 32'(w_empty[d]), 32'd1);
      chk("rst_ovf", d, 32'(w_ovf[d]), 32'd0);
    end
    i_Reset = 1'b1;
    repeat (5) step(1'b0, 8'h00, 1'b0);

    // 0x2E, then 0xA5 queued during its frame, then a dropped third push
    step(1'b1, 8'h2E, 1'b0);
    wait_started();
    step(1'b1, 8'hA5, 1'b0);
    for (int d = 0; d < ND; d++) chk("full_during_frame", d, 32'(w_full[d]), 32'd1);
    step(1'b1, 8'h77, 1'b0);
    for (int d = 0; d < ND; d++) chk("ovf_set", d, 32'(w_ovf[d]), 32'd1);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    for (int d = 0; d < ND; d++) chk("ovf_sticky", d, 32'(w_ovf[d]), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    for (int d = 0; d < ND; d++) chk("ovf_cleared", d, 32'(w_ovf[d]), 32'd0);
    wait_started();
    for (int d = 0; d < ND; d++) chk("back_to_back_gap", d, 32'(gap_last[d]), 32'd0);
    drain();

    // Parity of 0x01
    step(1'b1, 8'h01, 1'b0);
    drain();

    // Push, then a push on the very edge that transfers the first one
    while (div != 2) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int d = 0; d < ND; d++) begin
      chk("coincident_no_ovf", d, 32'(w_ovf[d]), 32'd0);
      chk("coincident_full", d, 32'(w_full[d]), 32'd1);
    end
    drain();

    // Randomised traffic
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 9) == 0), 8'($urandom), ($urandom_range(0, 24) == 0));
    drain();
    step(1'b0, 8'h00, 1'b1);

    // Reset in the middle of data bit 3 with a byte waiting
    step(1'b1, 8'h96, 1'b0);
    wait_started();
    step(1'b1, 8'h11, 1'b0);
    begin
      int n = 0;
      while (!(in_frame[0] && pos[0] == 4) && n < 200) begin step(1'b0, 8'h00, 1'b0); n++; end
    end
    chk("reached_bit3", 0, 32'(pos[0]), 32'd4);
    for (int d = 0; d < ND; d++) chk("pre_rst_full", d, 32'(w_full[d]), 32'd1);
    #2;
    i_Reset = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("async_rst_tx", d, 32'(w_tx[d]), 32'd1);
      chk("async_rst_full", d, 32'(w_full[d]), 32'd0);
      chk("async_rst_busy", d, 32'(w_busy[d]), 32'd0);
      exp_q[d].delete();
      in_frame[d] = 1'b0; pos[d] = 0; idle_cnt[d] = 0; ovf_exp[d] = 1'b0;
    end
    i_BitEn = 1'b0; i_Push = 1'b0; i_ClrOvf = 1'b0;
    repeat (2) @(negedge clk);
    i_Reset = 1'b1;
    repeat (4) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usrt_tx.md
# usrt_tx

Transmit path of the USRT: a one-byte transmit holding register written by the bus side, feeding a shift register that serialises frames (start, data LSB first, optional parity, stop) onto the line. Bit timing comes from a one-cycle bit-enable strobe supplied by the shared serial clock generator. It is the transmit-side counterpart of the receive data register and deserialiser.

## Interface
- DATA_W, 8: data bits per frame (5..9).
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits per frame (1 or 2).

- i_Pclk  in  1  system clock; all state changes on its rising edge.
- i_Reset  in  1  asynchronous, active-low reset.
- i_BitEn  in  1  one-cycle strobe marking each serial bit boundary.
- i_Push  in  1  write i_Data into the holding register.
- i_Data  in  DATA_W  byte to transmit.
- i_ClrOvf  in  1  clears o_Ovf.
- o_Tx  out  1  serial line; idle high.
- o_Full  out  1  holding register occupied.
- o_Busy  out  1  frame in progress (state not IDLE).
- o_Empty  out  1  holding register empty and not busy (transmission complete).
- o_Ovf  out  1  sticky: a push was dropped.

## Operation
- Reset values: o_Tx=1, o_Full=0, o_Busy=0, o_Empty=1, o_Ovf=0, state IDLE, holding/shift registers 0.
- Holding register: i_Push with o_Full=0 stores i_Data, sets o_Full. i_Push with o_Full=1 and no transfer that cycle: data dropped, o_Ovf set. Push in the same cycle as a transfer is accepted (no overflow).
- Transfer: in IDLE, when o_Full=1 and i_BitEn=1, holding register copies into the shift register, o_Full clears, state goes START.
- FSM, advancing only on i_BitEn:
  - IDLE: o_Tx=1.
  - START: o_Tx=0, then DATA.
  - DATA: o_Tx = shift[0]; shift right each i_BitEn; after DATA_W bits go to PARITY (PARITY≠0) else STOP.
  - PARITY: o_Tx = XOR of data (even) or its inverse (odd), then STOP.
  - STOP: o_Tx=1 for STOP_BITS bit periods, then IDLE. If o_Full=1 at the final i_BitEn, transfer immediately and go to START (back-to-back frames, no idle bit).
- Parity is computed from the byte at transfer time and held in a register.
- i_ClrOvf clears o_Ovf; a simultaneous new overflow wins (o_Ovf stays 1).
- Reset asserted mid-frame: o_Tx returns to 1 asynchronously, frame abandoned, holding data lost.
- i_Push and i_ClrOvf are honoured on every clock, independent of i_BitEn.

## Timing
- o_Tx is registered. Each bit lasts from one i_BitEn to the next.
- Push at edge n → o_Full=1 after edge n.
- Transfer at edge t → o_Tx=0 (start bit) after edge t, o_Busy=1, o_Full=0.
- Frame length: 1 + DATA_W + (PARITY≠0) + STOP_BITS bit periods.
- o_Empty = !o_Full && !o_Busy. It rises after the edge that leaves STOP for IDLE.

## Structure
- Shared package usrt_pkg: state enum (IDLE, START, DATA, PARITY, STOP) and parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD), shared with the receiver.
- One sub-module: txdatreg. It is the holding register with push, transfer, full and overflow logic, mirroring the receive data register. The FSM, shift register and bit counter stay in usrt_tx.

## Test plan
- Reset, then push 0x2E with i_BitEn every 4 cycles, PARITY=0 → o_Tx per bit: 0, 0,1,1,1,0,1,0,0, 1. o_Empty returns to 1 after the stop bit.
- PARITY=1, push 0x2E → parity bit 0. PARITY=2 → parity bit 1. PARITY=1, push 0x01 → parity bit 1.
- Push 0xA5 during the frame of 0x2E → o_Full=1 during 0x2E. Frames are back-to-back: start bit of 0xA5 follows the stop of 0x2E with no idle bit.
- Third push while busy with o_Full=1 → data dropped, o_Ovf=1 until i_ClrOvf. Push coincident with transfer → no overflow.
- STOP_BITS=2 → two high bit periods before the next start bit.
- Assert reset during DATA bit 3 → o_Tx=1, o_Full=0, o_Busy=0 immediately. After release, the next push transmits normally.
